// File: rtl/xor4_bist_controller_pkg.sv
// +---------------------------------------------------------------------------+
// | Package : xor4_bist_pkg                                                   |
// | Brief   : State encoding, pattern limits and golden model for XOR4 BIST   |
// | Rev     : 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

package xor4_bist_pkg;

   localparam int PAT_W = 4;
   localparam logic [PAT_W-1:0] PAT_LAST = 4'd15;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Returns {e,f,g} for pattern {d,c,b,a}
   function automatic logic [2:0] golden_efg(input logic [PAT_W-1:0] pat);
      logic e;
      logic f;
      logic g;
      e = pat[0] ^ pat[1];
      f = pat[2] ^ pat[3];
      g = ^pat;
      return {e, f, g};
   endfunction

endpackage

`default_nettype wire

// File: rtl/xor4_bist_controller_if.sv
// +---------------------------------------------------------------------------+
// | Interface : xor4_bist_controller_if                                       |
// | Brief     : Control/status and gate-side signals of the XOR4 BIST         |
// | Rev       : 1.0                                                           |
// +---------------------------------------------------------------------------+
`default_nettype none

interface xor4_bist_controller_if;
   import xor4_bist_pkg::*;

   logic             start;
   logic             abort;
   logic             pat_a;
   logic             pat_b;
   logic             pat_c;
   logic             pat_d;
   logic             dut_e;
   logic             dut_f;
   logic             dut_g;
   logic             busy;
   logic             done;
   logic             pass;
   logic [4:0]       err_cnt;
   logic             fail_valid;
   logic [PAT_W-1:0] fail_pat;

   modport master (
      input  start, abort, dut_e, dut_f, dut_g,
      output pat_a, pat_b, pat_c, pat_d,
      output busy, done, pass, err_cnt, fail_valid, fail_pat
   );

   modport slave (
      output start, abort, dut_e, dut_f, dut_g,
      input  pat_a, pat_b, pat_c, pat_d,
      input  busy, done, pass, err_cnt, fail_valid, fail_pat
   );

endinterface

`default_nettype wire

// File: rtl/xor4_bist_controller_checker.sv
// +---------------------------------------------------------------------------+
// | Module : xor4_bist_checker                                                |
// | Brief  : Golden compare with error counter and first-fail capture         |
// | Rev    : 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module xor4_bist_checker
   import xor4_bist_pkg::*;
(
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             clear,
   input  wire logic             check_en,
   input  wire logic [PAT_W-1:0] pat,
   input  wire logic [2:0]       efg,
   output logic [4:0]            err_cnt,
   output logic                  fail_valid,
   output logic [PAT_W-1:0]      fail_pat
);

   logic mismatch;

   assign mismatch = (efg != golden_efg(pat));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt    <= '0;
         fail_valid <= 1'b0;
         fail_pat   <= '0;
      end else if (clear) begin
         err_cnt    <= '0;
         fail_valid <= 1'b0;
         fail_pat   <= '0;
      end else if (check_en && mismatch) begin
         // Saturate at 16 so a full-fail sweep never wraps
         if (err_cnt != 5'd16) begin
            err_cnt <= err_cnt + 5'd1;
         end
         if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_pat   <= pat;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/xor4_bist_controller.sv
// +---------------------------------------------------------------------------+
// | Module : xor4_bist_controller                                             |
// | Brief  : Sweeps 16 patterns over the XOR4 gate and checks e/f/g.          |
// |          XOR4_BIST_STOP_ON_FAIL_EN: end the sweep at the first mismatch.  |
// | Rev    : 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module xor4_bist_controller
   import xor4_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
)
(
   input  wire logic              clk,
   input  wire logic              rst_n,
   xor4_bist_controller_if.master bus
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [PAT_W-1:0] pat;
   logic [PAT_W-1:0] pat_nxt;
   logic [3:0]       settle_cnt;
   logic [3:0]       settle_nxt;
   logic             pass_r;
   logic             pass_nxt;
   logic             sweep_start;
   logic             check_en;
   logic             stop_now;
   logic [2:0]       efg;

   assign efg = {bus.dut_e, bus.dut_f, bus.dut_g};

`ifdef XOR4_BIST_STOP_ON_FAIL_EN
   assign stop_now = (efg != golden_efg(pat));
`else
   assign stop_now = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pat        <= '0;
         settle_cnt <= '0;
         pass_r     <= 1'b0;
      end else begin
         state      <= state_nxt;
         pat        <= pat_nxt;
         settle_cnt <= settle_nxt;
         pass_r     <= pass_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pat_nxt     = pat;
      settle_nxt  = settle_cnt;
      pass_nxt    = pass_r;
      sweep_start = 1'b0;
      check_en    = 1'b0;
      if (bus.abort) begin
         state_nxt = IDLE;
         pat_nxt   = '0;
         pass_nxt  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state_nxt   = APPLY;
                  pat_nxt     = '0;
                  pass_nxt    = 1'b0;
                  sweep_start = 1'b1;
               end
            end
            APPLY: begin
               state_nxt  = SETTLE;
               settle_nxt = SETTLE_LOAD;
            end
            SETTLE: begin
               if (settle_cnt == 4'd0) begin
                  state_nxt = CHECK;
               end else begin
                  settle_nxt = settle_cnt - 4'd1;
               end
            end
            CHECK: begin
               check_en = 1'b1;
               if (stop_now || (pat == PAT_LAST)) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = APPLY;
                  pat_nxt   = pat + 4'd1;
               end
            end
            DONE: begin
               state_nxt = IDLE;
               pass_nxt  = (bus.err_cnt == 5'd0);
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   xor4_bist_checker u_checker (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (sweep_start),
      .check_en   (check_en),
      .pat        (pat),
      .efg        (efg),
      .err_cnt    (bus.err_cnt),
      .fail_valid (bus.fail_valid),
      .fail_pat   (bus.fail_pat)
   );

   assign bus.pat_a = pat[0];
   assign bus.pat_b = pat[1];
   assign bus.pat_c = pat[2];
   assign bus.pat_d = pat[3];
   assign bus.busy  = (state == APPLY) || (state == SETTLE) || (state == CHECK);
   assign bus.done  = (state == DONE);
   assign bus.pass  = pass_r;

endmodule

`default_nettype wire
